// File: rtl/display_pkg.sv
// Shared encodings for the display monitor: segment codes, digit markers, anode phases.
// Also holds a helper to classify an anode pattern and one to turn a tens/ones pair into binary.
package display_pkg;

  localparam logic [6:0] SEG_0    = 7'h7E;
  localparam logic [6:0] SEG_1    = 7'h30;
  localparam logic [6:0] SEG_2    = 7'h6D;
  localparam logic [6:0] SEG_3    = 7'h79;
  localparam logic [6:0] SEG_4    = 7'h33;
  localparam logic [6:0] SEG_5    = 7'h5B;
  localparam logic [6:0] SEG_6    = 7'h5F;
  localparam logic [6:0] SEG_7    = 7'h70;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h7B;
  localparam logic [6:0] SEG_DASH = 7'h01;

  localparam logic [3:0] DIG_DASH = 4'hF;
  localparam logic [3:0] DIG_BAD  = 4'hE;

  localparam logic [7:0] AN_PH0 = 8'h11;
  localparam logic [7:0] AN_PH1 = 8'h22;
  localparam logic [7:0] AN_PH2 = 8'h44;
  localparam logic [7:0] AN_PH3 = 8'h88;

  localparam int DP_BIT = 7;

  typedef struct packed {
    logic       legal;
    logic       blank;
    logic [1:0] phase;
  } an_class_t;

  function automatic an_class_t classify_an(input logic [7:0] an_val);
    an_class_t c;
    c = '{legal: 1'b1, blank: 1'b0, phase: 2'd0};
    case (an_val)
      AN_PH0:  c.phase = 2'd0;
      AN_PH1:  c.phase = 2'd1;
      AN_PH2:  c.phase = 2'd2;
      AN_PH3:  c.phase = 2'd3;
      8'h00: begin
        c.legal = 1'b0;
        c.blank = 1'b1;
      end
      default: c.legal = 1'b0;
    endcase
    return c;
  endfunction

  function automatic logic [7:0] pair_to_bin(input logic [3:0] tens, input logic [3:0] ones);
    return (8'(tens) * 8'd10) + 8'(ones);
  endfunction

endpackage

// File: rtl/seg_to_digit.sv
// Inverse seven-segment decoder: abcdefg code to a digit, dash marker or bad marker.
module seg_to_digit
  import display_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] digit
);

  always_comb begin
    case (seg)
      SEG_0:    digit = 4'd0;
      SEG_1:    digit = 4'd1;
      SEG_2:    digit = 4'd2;
      SEG_3:    digit = 4'd3;
      SEG_4:    digit = 4'd4;
      SEG_5:    digit = 4'd5;
      SEG_6:    digit = 4'd6;
      SEG_7:    digit = 4'd7;
      SEG_8:    digit = 4'd8;
      SEG_9:    digit = 4'd9;
      SEG_DASH: digit = DIG_DASH;
      default:  digit = DIG_BAD;
    endcase
  end

endmodule

// File: rtl/display_monitor.sv
// Samples the multiplexed anode/segment lines, rebuilds the eight shown digits and
// reports the decoded time plus scan-integrity errors and a stalled-scan flag.
module display_monitor
  import display_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] an,
  input  logic [7:0] duan,
  input  logic [7:0] duan1,
  output logic       frame_valid,
  output logic       frame_err,
  output logic       order_err,
  output logic       an_err,
  output logic       stale,
  output logic [7:0] hours,
  output logic [7:0] minutes,
  output logic [7:0] seconds,
  output logic [7:0] centisec,
  output logic [7:0] dp_mask
);

  localparam int SW = 24;
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] STAB_MAX = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] STAB_ARM = CW'(STABLE_CYCLES - 2);
  localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES);

  logic [SYNC_STAGES-1:0][SW-1:0] sync_q, sync_d;
  logic [SW-1:0]  samp_q, samp_d;
  logic [CW-1:0]  stab_q, stab_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic [3:0]     mask_q, mask_d;
  logic [1:0]     exp_q, exp_d;
  logic           done_q, done_d;
  logic [7:0][3:0] dig_q, dig_d;
  logic [7:0]     dpl_q, dpl_d;
  logic [7:0]     hours_q, hours_d, minutes_q, minutes_d;
  logic [7:0]     seconds_q, seconds_d, centisec_q, centisec_d;
  logic [7:0]     dp_mask_q, dp_mask_d;
  logic           fv_q, fv_d, fe_q, fe_d, oe_q, oe_d, ae_q, ae_d;

  logic [SW-1:0]  cur;
  logic           same, capture, all_ok;
  an_class_t      cls;
  logic [1:0][6:0] seg_in;
  logic [1:0][3:0] dec;

  assign cur       = sync_q[SYNC_STAGES-1];
  assign seg_in[0] = cur[14:8];
  assign seg_in[1] = cur[6:0];
  assign cls       = classify_an(cur[23:16]);

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_dec
      seg_to_digit u_dec (
        .seg   (seg_in[gi]),
        .digit (dec[gi])
      );
    end
  endgenerate

  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = {an, duan, duan1};
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  // One capture per dwell: fire on the single cycle the counter steps onto its ceiling.
  always_comb begin
    samp_d  = cur;
    same    = (cur == samp_q);
    capture = same && (stab_q == STAB_ARM);
    if (!same) begin
      stab_d = '0;
    end else if (stab_q == STAB_MAX) begin
      stab_d = stab_q;
    end else begin
      stab_d = stab_q + CW'(1);
    end
  end

  always_comb begin
    mask_d     = done_q ? 4'b0000 : mask_q;
    exp_d      = exp_q;
    done_d     = 1'b0;
    dig_d      = dig_q;
    dpl_d      = dpl_q;
    hours_d    = hours_q;
    minutes_d  = minutes_q;
    seconds_d  = seconds_q;
    centisec_d = centisec_q;
    dp_mask_d  = dp_mask_q;
    fv_d       = 1'b0;
    fe_d       = 1'b0;
    oe_d       = 1'b0;
    ae_d       = 1'b0;
    all_ok     = 1'b1;
    tmo_d      = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + TW'(1);

    if (capture) begin
      if (cls.legal) begin
        tmo_d                   = '0;
        dig_d[{1'b0, cls.phase}] = dec[0];
        dig_d[{1'b1, cls.phase}] = dec[1];
        dpl_d[{1'b0, cls.phase}] = cur[8 + DP_BIT];
        dpl_d[{1'b1, cls.phase}] = cur[DP_BIT];
        // An in-order phase 0 always opens a fresh frame, so 4'b1111 is only reachable by 0,1,2,3.
        if ((cls.phase == exp_q) && !mask_d[cls.phase]) begin
          mask_d = (cls.phase == 2'd0) ? 4'b0001 : (mask_d | (4'b0001 << cls.phase));
        end else begin
          oe_d   = 1'b1;
          mask_d = 4'b0001 << cls.phase;
        end
        exp_d = cls.phase + 2'd1;
        if (mask_d == 4'b1111) begin
          done_d = 1'b1;
          for (int i = 0; i < 8; i++) begin
            if (dig_d[i] > 4'd9) all_ok = 1'b0;
          end
          if (all_ok) begin
            fv_d       = 1'b1;
            hours_d    = pair_to_bin(dig_d[0], dig_d[1]);
            minutes_d  = pair_to_bin(dig_d[2], dig_d[3]);
            seconds_d  = pair_to_bin(dig_d[4], dig_d[5]);
            centisec_d = pair_to_bin(dig_d[6], dig_d[7]);
            dp_mask_d  = dpl_d;
          end else begin
            fe_d = 1'b1;
          end
        end
      end else if (!cls.blank) begin
        ae_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '0;
      samp_q     <= '0;
      stab_q     <= '0;
      tmo_q      <= '0;
      mask_q     <= '0;
      exp_q      <= '0;
      done_q     <= 1'b0;
      dig_q      <= '0;
      dpl_q      <= '0;
      hours_q    <= '0;
      minutes_q  <= '0;
      seconds_q  <= '0;
      centisec_q <= '0;
      dp_mask_q  <= '0;
      fv_q       <= 1'b0;
      fe_q       <= 1'b0;
      oe_q       <= 1'b0;
      ae_q       <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      samp_q     <= samp_d;
      stab_q     <= stab_d;
      tmo_q      <= tmo_d;
      mask_q     <= mask_d;
      exp_q      <= exp_d;
      done_q     <= done_d;
      dig_q      <= dig_d;
      dpl_q      <= dpl_d;
      hours_q    <= hours_d;
      minutes_q  <= minutes_d;
      seconds_q  <= seconds_d;
      centisec_q <= centisec_d;
      dp_mask_q  <= dp_mask_d;
      fv_q       <= fv_d;
      fe_q       <= fe_d;
      oe_q       <= oe_d;
      ae_q       <= ae_d;
    end
  end

  assign frame_valid = fv_q;
  assign frame_err   = fe_q;
  assign order_err   = oe_q;
  assign an_err      = ae_q;
  assign stale       = (tmo_q == TMO_MAX);
  assign hours       = hours_q;
  assign minutes     = minutes_q;
  assign seconds     = seconds_q;
  assign centisec    = centisec_q;
  assign dp_mask     = dp_mask_q;

endmodule

// File: tb/tb_display_monitor.sv
// Directed and randomized scans of the display lines checked against a digit-level
// model of what a receiver should reconstruct from each held anode pattern.
module tb_display_monitor;

  localparam int TMO = 3000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] an, duan, duan1;
  logic       frame_valid, frame_err, order_err, an_err, stale;
  logic [7:0] hours, minutes, seconds, centisec, dp_mask;

  display_monitor #(
    .SYNC_STAGES    (2),
    .STABLE_CYCLES  (4),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .an          (an),
    .duan        (duan),
    .duan1       (duan1),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
    .order_err   (order_err),
    .an_err      (an_err),
    .stale       (stale),
    .hours       (hours),
    .minutes     (minutes),
    .seconds     (seconds),
    .centisec    (centisec),
    .dp_mask     (dp_mask)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int fv_seen = 0, fe_seen = 0, oe_seen = 0, ae_seen = 0, clash_seen = 0;
  always @(negedge clk) begin
    if (frame_valid === 1'b1) fv_seen <= fv_seen + 1;
    if (frame_err   === 1'b1) fe_seen <= fe_seen + 1;
    if (order_err   === 1'b1) oe_seen <= oe_seen + 1;
    if (an_err      === 1'b1) ae_seen <= ae_seen + 1;
    if ((frame_valid && frame_err) || (an_err && order_err)) clash_seen <= clash_seen + 1;
  end

  // Reference model: digits shown per anode, and how many phases of the current
  // frame have been seen strictly in order starting from phase 0.
  logic [6:0] seg_tab [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};
  int  m_fv = 0, m_fe = 0, m_oe = 0, m_ae = 0;
  int  m_exp = 0, m_run = 0;
  int  m_dig [8];
  bit  m_dp [8];
  int  m_hours = 0, m_minutes = 0, m_seconds = 0, m_centisec = 0, m_dpmask = 0;
  bit  m_stale = 0;
  logic [23:0] last_pat = '0;

  function automatic int seg_val(input logic [6:0] s);
    for (int i = 0; i < 10; i++) if (s == seg_tab[i]) return i;
    if (s == 7'h01) return 15;
    return 14;
  endfunction

  function automatic int an_phase(input logic [7:0] a);
    case (a)
      8'h11: return 0;
      8'h22: return 1;
      8'h44: return 2;
      8'h88: return 3;
      8'h00: return -1;
      default: return -2;
    endcase
  endfunction

  task automatic model_reset();
    m_exp = 0; m_run = 0; m_stale = 0;
    m_hours = 0; m_minutes = 0; m_seconds = 0; m_centisec = 0; m_dpmask = 0;
    for (int k = 0; k < 8; k++) begin
      m_dig[k] = 0;
      m_dp[k]  = 0;
    end
  endtask

  task automatic model_step(input logic [7:0] a, input logic [7:0] d0, input logic [7:0] d1);
    int  p;
    bit  good;
    p = an_phase(a);
    if (p == -2) begin
      m_ae++;
    end else if (p >= 0) begin
      m_stale = 0;
      m_dig[p] = seg_val(d0[6:0]);  m_dig[p+4] = seg_val(d1[6:0]);
      m_dp[p]  = d0[7];             m_dp[p+4]  = d1[7];
      if (p != m_exp) begin
        m_oe++;
        m_run = (p == 0) ? 1 : 0;
      end else if (p == 0) begin
        m_run = 1;
      end else if (m_run > 0) begin
        m_run++;
      end
      m_exp = (p + 1) % 4;
      if (p == 3 && m_run == 4) begin
        good = 1;
        for (int k = 0; k < 8; k++) if (m_dig[k] > 9) good = 0;
        if (good) begin
          m_fv++;
          m_hours    = 10 * m_dig[0] + m_dig[1];
          m_minutes  = 10 * m_dig[2] + m_dig[3];
          m_seconds  = 10 * m_dig[4] + m_dig[5];
          m_centisec = 10 * m_dig[6] + m_dig[7];
          m_dpmask   = 0;
          for (int k = 0; k < 8; k++) if (m_dp[k]) m_dpmask += (1 << k);
        end else begin
          m_fe++;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, " frame_valid_count"}, fv_seen, m_fv);
    chk({tag, " frame_err_count"},   fe_seen, m_fe);
    chk({tag, " order_err_count"},   oe_seen, m_oe);
    chk({tag, " an_err_count"},      ae_seen, m_ae);
    chk({tag, " hours"},    hours,    m_hours);
    chk({tag, " minutes"},  minutes,  m_minutes);
    chk({tag, " seconds"},  seconds,  m_seconds);
    chk({tag, " centisec"}, centisec, m_centisec);
    chk({tag, " dp_mask"},  dp_mask,  m_dpmask);
    chk({tag, " stale"},    stale,    m_stale);
  endtask

  task automatic dwell(input logic [7:0] a, input logic [7:0] d0, input logic [7:0] d1, input int hold);
    @(negedge clk);
    an = a; duan = d0; duan1 = d1;
    repeat (hold) @(negedge clk);
    #1;
    model_step(a, d0, d1);
    if (hold > TMO && an_phase(a) >= 0) m_stale = 1;
    last_pat = {a, d0, d1};
    $display("dwell an=%02h duan=%02h duan1=%02h hold=%0d -> fv=%0d fe=%0d oe=%0d ae=%0d time=%0d:%0d:%0d.%0d",
             a, d0, d1, hold, fv_seen, fe_seen, oe_seen, ae_seen, hours, minutes, seconds, centisec);
    check_state($sformatf("an=%02h", a));
  endtask

  function automatic logic [7:0] rand_seg();
    int k;
    logic [7:0] s;
    k = $urandom_range(0, 99);
    if (k < 95)      s = {1'b0, seg_tab[$urandom_range(0, 9)]};
    else if (k < 97) s = 8'h01;
    else             s = 8'($urandom_range(0, 127));
    s[7] = 1'($urandom_range(0, 1));
    return s;
  endfunction

  initial begin
    logic [7:0] ra, rd0, rd1;
    int r, p;

    rst_n = 1'b0; an = '0; duan = '0; duan1 = '0;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    check_state("reset");
    chk("reset frame_valid", frame_valid, 0);
    chk("reset order_err",   order_err,   0);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);

    // 12.34.56.78 with dots on AN1, AN3, AN5
    dwell(8'h11, 8'h30, 8'h5B, 100);
    dwell(8'h22, 8'hED, 8'hDF, 100);
    dwell(8'h44, 8'h79, 8'h70, 100);
    dwell(8'h88, 8'hB3, 8'h7F, 100);
    chk("scan hours", hours, 12);
    chk("scan minutes", minutes, 34);
    chk("scan seconds", seconds, 56);
    chk("scan centisec", centisec, 78);
    chk("scan dp_mask", dp_mask, 8'h2A);
    chk("scan frames", fv_seen, 1);

    // two-cycle glitch of phase 1 must not be captured
    @(negedge clk);
    an = 8'h22; duan = 8'h6D; duan1 = 8'h5B;
    repeat (2) @(negedge clk);
    dwell(8'h11, 8'h6D, 8'h5B, 10);
    chk("glitch order_err", oe_seen, 0);
    dwell(8'h22, 8'hF9, 8'h7B, 10);
    dwell(8'h44, 8'h5B, 8'h7B, 10);
    dwell(8'h88, 8'h7B, 8'h7B, 10);
    chk("glitch hours", hours, 23);
    chk("glitch centisec", centisec, 99);

    // out-of-order 0,1,3 then a clean 01.02.03.04
    dwell(8'h11, 8'h7E, 8'h7E, 10);
    dwell(8'h22, 8'h30, 8'h79, 10);
    dwell(8'h88, 8'h6D, 8'h33, 10);
    chk("order order_err", oe_seen, 1);
    dwell(8'h11, 8'h7E, 8'h7E, 10);
    dwell(8'h22, 8'h30, 8'h79, 10);
    dwell(8'h44, 8'h7E, 8'h7E, 10);
    dwell(8'h88, 8'h6D, 8'h33, 10);
    chk("order frames", fv_seen, 3);
    chk("order minutes", minutes, 2);

    // dash on AN6 spoils the frame
    dwell(8'h11, 8'h30, 8'h30, 10);
    dwell(8'h22, 8'h30, 8'h30, 10);
    dwell(8'h44, 8'h30, 8'h01, 10);
    dwell(8'h88, 8'h30, 8'h30, 10);
    chk("dash frame_err", fe_seen, 1);
    chk("dash hours held", hours, 1);

    // illegal anode mid-frame leaves the partial frame intact
    dwell(8'h11, 8'h6D, 8'h6D, 10);
    dwell(8'h22, 8'h6D, 8'h6D, 10);
    dwell(8'h03, 8'h6D, 8'h6D, 10);
    dwell(8'h44, 8'h6D, 8'h6D, 10);
    dwell(8'h88, 8'h6D, 8'h6D, 10);
    chk("an_err count", ae_seen, 1);
    chk("an_err hours", hours, 22);

    for (int n = 0; n < 150; n++) begin
      do begin
        r = $urandom_range(0, 99);
        if (r < 70)      p = m_exp;
        else if (r < 80) p = $urandom_range(0, 3);
        else if (r < 88) p = -1;
        else             p = -2;
        if (p >= 0)       ra = 8'h11 << p;
        else if (p == -1) ra = 8'h00;
        else begin
          do ra = 8'($urandom_range(1, 255)); while (an_phase(ra) != -2);
        end
        rd0 = rand_seg();
        rd1 = rand_seg();
      end while ({ra, rd0, rd1} == last_pat);
      dwell(ra, rd0, rd1, $urandom_range(7, 12));
    end

    // frozen legal pattern: stale rises, next legal capture clears it
    ra = 8'h11 << m_exp;
    if ({ra, 8'h30, 8'h30} == last_pat) ra = 8'h11 << ((m_exp + 1) % 4);
    dwell(ra, 8'h30, 8'h30, TMO + 40);
    chk("stale raised", stale, 1);
    ra = 8'h11 << m_exp;
    dwell(ra, 8'h79, 8'h79, 10);
    chk("stale cleared", stale, 0);

    // asynchronous reset in the middle of a frame
    dwell(8'h11, 8'h7E, 8'h30, 10);
    dwell(8'h22, 8'h30, 8'h30, 10);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("async rst hours", hours, 0);
    chk("async rst dp_mask", dp_mask, 0);
    chk("async rst frame_valid", frame_valid, 0);
    an = '0; duan = '0; duan1 = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    last_pat = '0;
    dwell(8'h44, 8'h5B, 8'h5B, 10);
    dwell(8'h88, 8'h5B, 8'h5B, 10);
    chk("post-reset partial frames", fv_seen, m_fv);
    dwell(8'h11, 8'h79, 8'h33, 10);
    dwell(8'h22, 8'h33, 8'h79, 10);
    dwell(8'h44, 8'h5B, 8'h5F, 10);
    dwell(8'h88, 8'h70, 8'h7F, 10);
    chk("post-reset hours", hours, 34);
    chk("post-reset centisec", centisec, 68);

    chk("pulse exclusivity", clash_seen, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
